// File: rtl/mp_ram_pkg.sv
// Shared types and helpers for the N-port RAM: arbitration policy,
// byte-lane width and the rotated-priority rank used by the arbiter.
package mp_ram_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    localparam int BYTE_W = 8;

    // Rank 0 is the highest priority; the port at rr_ptr gets rank 0.
    function automatic int prio_rank(input int port, input int rr_ptr, input int num_ports);
        return (port - rr_ptr + num_ports) % num_ports;
    endfunction

endpackage

// File: rtl/mp_ram_if.sv
// Per-port request/response bundle of the N-port RAM, all ports flattened
// into slices (port i occupies slice i of every vector).
interface mp_ram_if
    import mp_ram_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8
);
    localparam int BE_W = DATA_W / BYTE_W;

    logic [NUM_PORTS-1:0]        valid;
    logic [NUM_PORTS-1:0]        ready;
    logic [NUM_PORTS-1:0]        we;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*DATA_W-1:0] wdata;
    logic [NUM_PORTS*BE_W-1:0]   be;
    logic [NUM_PORTS*DATA_W-1:0] rdata;
    logic [NUM_PORTS-1:0]        rvalid;

    modport master (
        output valid, we, addr, wdata, be,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  valid, we, addr, wdata, be,
        output ready, rdata, rvalid
    );

endinterface

// File: rtl/mp_ram_arb.sv
// Pure combinational collision arbiter: a port is held off whenever a
// higher-priority port targets the same address and either side writes.
module mp_ram_arb
    import mp_ram_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 8,
    parameter int ARB_MODE  = 0,
    parameter int PTR_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0]        valid,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [PTR_W-1:0]            rr_ptr,
    output logic [NUM_PORTS-1:0]        ready,
    output logic                        any_stall
);

    localparam arb_mode_e MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic blocked;
            // Conservative: a higher-priority conflicting port blocks us
            // even if that port is itself blocked by someone else.
            always_comb begin
                blocked = 1'b0;
                for (int j = 0; j < NUM_PORTS; j++) begin
                    if (j != gi && valid[gi] && valid[j] &&
                        addr[gi*ADDR_W +: ADDR_W] == addr[j*ADDR_W +: ADDR_W] &&
                        (we[gi] || we[j])) begin
                        if (MODE == ARB_FIXED) begin
                            if (j < gi) blocked = 1'b1;
                        end else begin
                            if (prio_rank(j, int'(rr_ptr), NUM_PORTS) <
                                prio_rank(gi, int'(rr_ptr), NUM_PORTS)) blocked = 1'b1;
                        end
                    end
                end
            end
            assign ready[gi] = ~blocked;
        end
    endgenerate

    assign any_stall = |(valid & ~ready);

endmodule

// File: rtl/mp_ram.sv
// N-port synchronous RAM with byte enables, registered reads, collision
// arbitration and a saturating count of stall cycles.
module mp_ram
    import mp_ram_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int ARB_MODE  = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    mp_ram_if.slave          bus,
    output logic [CNT_W-1:0] collision_cnt
);

    localparam int        BE_W  = DATA_W / BYTE_W;
    localparam int        PTR_W = $clog2(NUM_PORTS);
    localparam arb_mode_e MODE  = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

    logic [DATA_W-1:0]           mem [DEPTH];
    logic [PTR_W-1:0]            rr_ptr_reg;
    logic [CNT_W-1:0]            cnt_reg;
    logic [NUM_PORTS*DATA_W-1:0] rdata_reg;
    logic [NUM_PORTS-1:0]        rvalid_reg;
    logic [NUM_PORTS-1:0]        ready;
    logic [NUM_PORTS-1:0]        accept;
    logic                        any_stall;

    mp_ram_arb #(
        .NUM_PORTS (NUM_PORTS),
        .ADDR_W    (ADDR_W),
        .ARB_MODE  (ARB_MODE),
        .PTR_W     (PTR_W)
    ) u_arb (
        .valid     (bus.valid),
        .we        (bus.we),
        .addr      (bus.addr),
        .rr_ptr    (rr_ptr_reg),
        .ready     (ready),
        .any_stall (any_stall)
    );

    // ready stays visible during reset, but nothing is taken while rst is high.
    assign accept = bus.valid & ready & {NUM_PORTS{~rst}};

    // Accepted writes never share an address, so loop order is irrelevant.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (accept[p] && bus.we[p]) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (bus.be[p*BE_W + b]) begin
                        mem[bus.addr[p*ADDR_W +: ADDR_W]][b*BYTE_W +: BYTE_W]
                            <= bus.wdata[p*DATA_W + b*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_reg  <= '0;
            rvalid_reg <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rvalid_reg[p] <= accept[p] & ~bus.we[p];
                if (accept[p] && !bus.we[p]) begin
                    rdata_reg[p*DATA_W +: DATA_W] <= mem[bus.addr[p*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else if (any_stall) begin
            if (cnt_reg != {CNT_W{1'b1}}) cnt_reg <= cnt_reg + CNT_W'(1);
            if (MODE == ARB_RR) begin
                rr_ptr_reg <= (rr_ptr_reg == PTR_W'(NUM_PORTS - 1)) ? '0
                                                                    : rr_ptr_reg + PTR_W'(1);
            end
        end
    end

    assign bus.ready     = ready;
    assign bus.rdata     = rdata_reg;
    assign bus.rvalid    = rvalid_reg;
    assign collision_cnt = cnt_reg;

endmodule

// File: tb/tb_mp_ram.sv
// Directed bench for mp_ram: one round-robin instance and one
// fixed-priority instance share clock and reset.
module tb_mp_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rr_cnt;
    logic [15:0] fx_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mp_ram_if #(.NUM_PORTS(4), .DATA_W(32), .ADDR_W(8)) rr_if ();
    mp_ram_if #(.NUM_PORTS(4), .DATA_W(32), .ADDR_W(8)) fx_if ();

    mp_ram #(.NUM_PORTS(4), .DATA_W(32), .DEPTH(256), .ARB_MODE(0), .CNT_W(16)) dut_rr (
        .clk(clk), .rst(rst), .bus(rr_if), .collision_cnt(rr_cnt)
    );

    mp_ram #(.NUM_PORTS(4), .DATA_W(32), .DEPTH(256), .ARB_MODE(1), .CNT_W(16)) dut_fx (
        .clk(clk), .rst(rst), .bus(fx_if), .collision_cnt(fx_cnt)
    );

    task automatic drive(input int sel, input int p, input logic v, input logic w,
                         input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        if (sel == 0) begin
            rr_if.valid[p] = v;  rr_if.we[p] = w;  rr_if.addr[p*8 +: 8] = a;
            rr_if.wdata[p*32 +: 32] = d;  rr_if.be[p*4 +: 4] = b;
        end else begin
            fx_if.valid[p] = v;  fx_if.we[p] = w;  fx_if.addr[p*8 +: 8] = a;
            fx_if.wdata[p*32 +: 32] = d;  fx_if.be[p*4 +: 4] = b;
        end
    endtask

    task automatic idle_all();
        rr_if.valid = '0; rr_if.we = '0; rr_if.addr = '0; rr_if.wdata = '0; rr_if.be = '0;
        fx_if.valid = '0; fx_if.we = '0; fx_if.addr = '0; fx_if.wdata = '0; fx_if.be = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (rr_if.rvalid !== 4'b0000) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0000", rr_if.rvalid); end
        n_cmp++; if (rr_if.rdata !== 128'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rr_if.rdata); end
        n_cmp++; if (rr_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_rr_cnt: got %0d want 0", rr_cnt); end
        n_cmp++; if (fx_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_fx_cnt: got %0d want 0", fx_cnt); end
        n_cmp++; if (rr_if.ready !== 4'b1111) begin n_bad++; $display("FAIL reset_ready: got %b want 1111", rr_if.ready); end
        #2 rst = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        drive(0, 0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
        #1;
        n_cmp++; if (rr_if.ready[0] !== 1'b1) begin n_bad++; $display("FAIL wr_ready0: got %b want 1", rr_if.ready[0]); end
        step();
        idle_all();
        drive(0, 1, 1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
        step();
        idle_all();
        n_cmp++; if (rr_if.rvalid !== 4'b0010) begin n_bad++; $display("FAIL rd_rvalid: got %b want 0010", rr_if.rvalid); end
        n_cmp++; if (rr_if.rdata[32 +: 32] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_rdata1: got %h want deadbeef", rr_if.rdata[32 +: 32]); end
        n_cmp++; if (rr_cnt !== 16'd0) begin n_bad++; $display("FAIL rd_cnt: got %0d want 0", rr_cnt); end
        step();
        n_cmp++; if (rr_if.rvalid !== 4'b0000) begin n_bad++; $display("FAIL rd_pulse: got %b want 0000", rr_if.rvalid); end
        $display("test_write_read done");
    endtask

    task automatic test_byte_en();
        drive(0, 0, 1'b1, 1'b1, 8'h05, 32'h11223344, 4'hF);
        step();
        drive(0, 0, 1'b1, 1'b1, 8'h05, 32'hAABBCCDD, 4'h5);
        step();
        drive(0, 0, 1'b1, 1'b0, 8'h05, 32'h0, 4'h0);
        step();
        idle_all();
        n_cmp++; if (rr_if.rvalid[0] !== 1'b1) begin n_bad++; $display("FAIL be_rvalid: got %b want 1", rr_if.rvalid[0]); end
        n_cmp++; if (rr_if.rdata[0 +: 32] !== 32'h11BB33DD) begin n_bad++; $display("FAIL be_rdata: got %h want 11bb33dd", rr_if.rdata[0 +: 32]); end
        $display("test_byte_en done");
    endtask

    task automatic test_read_share();
        drive(0, 3, 1'b1, 1'b1, 8'h20, 32'h55, 4'hF);
        step();
        for (int p = 0; p < 4; p++) drive(0, p, 1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
        #1;
        n_cmp++; if (rr_if.ready !== 4'b1111) begin n_bad++; $display("FAIL share_ready: got %b want 1111", rr_if.ready); end
        step();
        idle_all();
        n_cmp++; if (rr_if.rvalid !== 4'b1111) begin n_bad++; $display("FAIL share_rvalid: got %b want 1111", rr_if.rvalid); end
        for (int p = 0; p < 4; p++) begin
            n_cmp++;
            if (rr_if.rdata[p*32 +: 32] !== 32'h55) begin
                n_bad++; $display("FAIL share_rdata%0d: got %h want 00000055", p, rr_if.rdata[p*32 +: 32]);
            end
        end
        n_cmp++; if (rr_cnt !== 16'd0) begin n_bad++; $display("FAIL share_cnt: got %0d want 0", rr_cnt); end
        $display("test_read_share done");
    endtask

    task automatic test_rr_collision();
        logic [3:0] got;
        logic [3:0] exp;
        for (int p = 0; p < 4; p++) drive(0, p, 1'b1, 1'b1, 8'h07, 32'(p), 4'hF);
        for (int k = 0; k < 4; k++) begin
            #1;
            got = rr_if.ready & rr_if.valid;
            exp = 4'b0001 << k;
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rr_accept_c%0d: got %b want %b", k, got, exp); end
            step();
            rr_if.valid = rr_if.valid & ~got;
        end
        n_cmp++; if (rr_cnt !== 16'd3) begin n_bad++; $display("FAIL rr_cnt: got %0d want 3", rr_cnt); end
        idle_all();
        drive(0, 0, 1'b1, 1'b0, 8'h07, 32'h0, 4'h0);
        step();
        idle_all();
        n_cmp++; if (rr_if.rdata[0 +: 32] !== 32'd3) begin n_bad++; $display("FAIL rr_mem7: got %h want 00000003", rr_if.rdata[0 +: 32]); end
        $display("test_rr_collision done");
    endtask

    task automatic test_fixed();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 1'b1, 1'b1, 8'h09, 32'h100 + 32'(k), 4'hF);
            drive(1, 2, 1'b1, 1'b0, 8'h09, 32'h0, 4'h0);
            #1;
            n_cmp++; if (fx_if.ready[2] !== 1'b0) begin n_bad++; $display("FAIL fx_stall_c%0d: got ready2=%b want 0", k, fx_if.ready[2]); end
            step();
        end
        drive(1, 0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        #1;
        n_cmp++; if (fx_if.ready[2] !== 1'b1) begin n_bad++; $display("FAIL fx_release: got ready2=%b want 1", fx_if.ready[2]); end
        step();
        idle_all();
        n_cmp++; if (fx_if.rvalid !== 4'b0100) begin n_bad++; $display("FAIL fx_rvalid: got %b want 0100", fx_if.rvalid); end
        n_cmp++; if (fx_if.rdata[64 +: 32] !== 32'h104) begin n_bad++; $display("FAIL fx_rdata2: got %h want 00000104", fx_if.rdata[64 +: 32]); end
        n_cmp++; if (fx_cnt !== 16'd5) begin n_bad++; $display("FAIL fx_cnt: got %0d want 5", fx_cnt); end
        $display("test_fixed done");
    endtask

    task automatic test_reset_mid_read();
        drive(0, 1, 1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
        step();
        rst = 1'b1;
        idle_all();
        #1;
        n_cmp++; if (rr_if.rvalid !== 4'b0000) begin n_bad++; $display("FAIL mid_rvalid: got %b want 0000", rr_if.rvalid); end
        n_cmp++; if (rr_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_cnt: got %0d want 0", rr_cnt); end
        n_cmp++; if (rr_if.rdata !== 128'h0) begin n_bad++; $display("FAIL mid_rdata: got %h want 0", rr_if.rdata); end
        #2 rst = 1'b0;
        // With rr_ptr back at 0, port 1 outranks port 3.
        drive(0, 1, 1'b1, 1'b1, 8'h30, 32'h1, 4'hF);
        drive(0, 3, 1'b1, 1'b1, 8'h30, 32'h3, 4'hF);
        #1;
        n_cmp++; if (rr_if.ready !== 4'b0111) begin n_bad++; $display("FAIL mid_rrptr: got ready=%b want 0111", rr_if.ready); end
        idle_all();
        step();
        drive(0, 0, 1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
        drive(0, 2, 1'b1, 1'b0, 8'h07, 32'h0, 4'h0);
        step();
        idle_all();
        n_cmp++; if (rr_if.rvalid !== 4'b0101) begin n_bad++; $display("FAIL post_rvalid: got %b want 0101", rr_if.rvalid); end
        n_cmp++; if (rr_if.rdata[0 +: 32] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL post_rdata0: got %h want deadbeef", rr_if.rdata[0 +: 32]); end
        n_cmp++; if (rr_if.rdata[64 +: 32] !== 32'd3) begin n_bad++; $display("FAIL post_rdata2: got %h want 00000003", rr_if.rdata[64 +: 32]); end
        $display("test_reset_mid_read done");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_en();
        test_read_share();
        test_rr_collision();
        test_fixed();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
